// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the I-cache (read-only) and the D-cache.
// Each grant is registered onto pmem and held until pmem_resp. An IDLE cycle always follows.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_d_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;

  // On a tie D wins unless round-robin is enabled and D took the previous grant.
  always_comb begin
    req_i   = i_read;
    req_d   = d_read | d_write;
    grant_d = req_d & (~req_i | (ROUND_ROBIN == 0) | ~last_d_q);
    grant_i = req_i & ~grant_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_d_q       <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q        <= SERVE_D;
            last_d_q       <= 1'b1;
            // A simultaneous read+write request is carried out as a write.
            pmem_read_q    <= d_read & ~d_write;
            pmem_write_q   <= d_write;
            pmem_address_q <= d_address;
            pmem_wdata_q   <= d_wdata;
          end else if (grant_i) begin
            state_q        <= SERVE_I;
            last_d_q       <= 1'b0;
            pmem_read_q    <= 1'b1;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= i_address;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state_q      <= IDLE;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle table, directed corner sequences, and a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, pmem_rdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [127:0] i_rdata, d_rdata, pmem_wdata;
  logic [15:0]  pmem_address;

  logic         f_i_read, f_d_read, f_d_write, f_pmem_resp;
  logic [15:0]  f_i_address, f_d_address;
  logic [127:0] f_d_wdata, f_pmem_rdata;
  logic         f_i_resp, f_d_resp, f_pmem_read, f_pmem_write;
  logic [127:0] f_i_rdata, f_d_rdata, f_pmem_wdata;
  logic [15:0]  f_pmem_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_read(f_i_read), .i_address(f_i_address), .i_resp(f_i_resp), .i_rdata(f_i_rdata),
    .d_read(f_d_read), .d_write(f_d_write), .d_address(f_d_address), .d_wdata(f_d_wdata),
    .d_resp(f_d_resp), .d_rdata(f_d_rdata),
    .pmem_read(f_pmem_read), .pmem_write(f_pmem_write), .pmem_address(f_pmem_address),
    .pmem_wdata(f_pmem_wdata), .pmem_resp(f_pmem_resp), .pmem_rdata(f_pmem_rdata)
  );

  typedef struct {
    logic         ir;
    logic [15:0]  ia;
    logic         dr;
    logic         dw;
    logic [15:0]  da;
    logic [127:0] dd;
    logic         pr;
    logic [127:0] prd;
    logic         e_ir;
    logic         e_dr;
    logic         e_pr;
    logic         e_pw;
    logic [15:0]  e_a;
    logic [127:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] W1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] W2 = 128'hFEDC_BA98_7654_3210_5A5A_C3C3_0F0F_1234;
  localparam logic [127:0] R1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] R2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                     input logic [15:0] da, input logic [127:0] dd, input logic pr,
                     input logic [127:0] prd);
    i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da; d_wdata = dd;
    pmem_resp = pr; pmem_rdata = prd;
  endtask

  task automatic add(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                     input logic [15:0] da, input logic [127:0] dd, input logic pr,
                     input logic [127:0] prd, input logic eir, input logic edr,
                     input logic epr, input logic epw, input logic [15:0] ea,
                     input logic [127:0] ewd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.pr = pr; v.prd = prd;
    v.e_ir = eir; v.e_dr = edr; v.e_pr = epr; v.e_pw = epw; v.e_a = ea; v.e_wd = ewd;
    tbl.push_back(v);
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_i_resp"}, i_resp, 1'b0);
    chk({tag, "_d_resp"}, d_resp, 1'b0);
    chk({tag, "_pmem_read"}, pmem_read, 1'b0);
    chk({tag, "_pmem_write"}, pmem_write, 1'b0);
  endtask

  // transaction-level reference state for the randomized phase
  bit           m_busy, m_side, m_last, m_wr;
  logic [15:0]  m_addr;
  logic [127:0] m_data;
  bit           i_pend, d_pend;
  int           n_done;

  initial begin
    rst_n = 1'b0;
    drv(0, '0, 0, 0, '0, '0, 0, '0);
    f_i_read = 0; f_d_read = 0; f_d_write = 0; f_pmem_resp = 0;
    f_i_address = '0; f_d_address = '0; f_d_wdata = '0; f_pmem_rdata = '0;
    #2;
    chk_idle_out("reset");
    chk("reset_addr", pmem_address, 16'h0);
    chk("reset_wdata", pmem_wdata, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // contention from reset: D, I, D, I with one IDLE cycle after each response
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,0,0,16'h0000,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,1,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 1,R1, 0,1,1,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,0,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,1,0,16'h1111,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 1,R2, 1,0,1,0,16'h1111,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,0,0,16'h1111,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,1,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 1,R1, 0,1,1,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,0,0,16'h2222,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 0,'0, 0,0,1,0,16'h1111,'0);
    add(1,16'h1111,1,0,16'h2222,'0, 1,R2, 1,0,1,0,16'h1111,'0);
    add(0,16'h0000,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h1111,'0);
    // single I read, 3-cycle pmem latency
    add(1,16'h1230,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h1111,'0);
    add(1,16'h1230,0,0,16'h0000,'0, 0,'0, 0,0,1,0,16'h1230,'0);
    add(1,16'h1230,0,0,16'h0000,'0, 0,'0, 0,0,1,0,16'h1230,'0);
    add(1,16'h1230,0,0,16'h0000,'0, 1,A5, 1,0,1,0,16'h1230,'0);
    add(0,16'h0000,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h1230,'0);
    // D writeback
    add(0,16'h0000,0,1,16'h4000,W1, 0,'0, 0,0,0,0,16'h1230,'0);
    add(0,16'h0000,0,1,16'h4000,W1, 0,'0, 0,0,0,1,16'h4000,W1);
    add(0,16'h0000,0,1,16'h4000,W1, 0,'0, 0,0,0,1,16'h4000,W1);
    add(0,16'h0000,0,1,16'h4000,W1, 1,R1, 0,1,0,1,16'h4000,W1);
    add(0,16'h0000,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h4000,'0);
    // illegal read+write performs the write
    add(0,16'h0000,1,1,16'h5550,W2, 0,'0, 0,0,0,0,16'h4000,'0);
    add(0,16'h0000,1,1,16'h5550,W2, 0,'0, 0,0,0,1,16'h5550,W2);
    add(0,16'h0000,1,1,16'h5550,W2, 1,R2, 0,1,0,1,16'h5550,W2);
    add(0,16'h0000,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h5550,'0);
    // stray response in IDLE
    add(0,16'h0000,0,0,16'h0000,'0, 1,A5, 0,0,0,0,16'h5550,'0);
    add(0,16'h0000,0,0,16'h0000,'0, 0,'0, 0,0,0,0,16'h5550,'0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drv(tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].da, tbl[k].dd, tbl[k].pr, tbl[k].prd);
      #1;
      chk($sformatf("row%0d_i_resp", k), i_resp, tbl[k].e_ir);
      chk($sformatf("row%0d_d_resp", k), d_resp, tbl[k].e_dr);
      chk($sformatf("row%0d_pmem_read", k), pmem_read, tbl[k].e_pr);
      chk($sformatf("row%0d_pmem_write", k), pmem_write, tbl[k].e_pw);
      chk($sformatf("row%0d_pmem_address", k), pmem_address, tbl[k].e_a);
      if (tbl[k].e_pw) chk($sformatf("row%0d_pmem_wdata", k), pmem_wdata, tbl[k].e_wd);
      if (tbl[k].e_ir) chk($sformatf("row%0d_i_rdata", k), i_rdata, tbl[k].prd);
      if (tbl[k].e_dr) chk($sformatf("row%0d_d_rdata", k), d_rdata, tbl[k].prd);
    end

    // requester drops mid-SERVE: transaction still completes
    @(negedge clk); drv(1, 16'h7770, 0, 0, '0, '0, 0, '0); #1;
    chk("drop_idle_read", pmem_read, 1'b0);
    @(negedge clk); #1;
    chk("drop_serve_read", pmem_read, 1'b1);
    chk("drop_serve_addr", pmem_address, 16'h7770);
    @(negedge clk); drv(0, 16'h0000, 0, 0, '0, '0, 0, '0); #1;
    chk("drop_held_read1", pmem_read, 1'b1);
    chk("drop_held_addr", pmem_address, 16'h7770);
    @(negedge clk); #1;
    chk("drop_held_read2", pmem_read, 1'b1);
    @(negedge clk); drv(0, 16'h0000, 0, 0, '0, '0, 1, R1); #1;
    chk("drop_i_resp", i_resp, 1'b1);
    chk("drop_i_rdata", i_rdata, R1);
    chk("drop_d_resp", d_resp, 1'b0);
    @(negedge clk); drv(0, 16'h0000, 0, 0, '0, '0, 0, '0); #1;
    chk_idle_out("drop_after");

    // asynchronous reset during SERVE_D
    @(negedge clk); drv(0, 16'h0000, 1, 0, 16'h8880, W1, 0, '0); #1;
    chk("rst_idle_read", pmem_read, 1'b0);
    @(negedge clk); #1;
    chk("rst_serve_read", pmem_read, 1'b1);
    chk("rst_serve_addr", pmem_address, 16'h8880);
    #2;
    pmem_resp = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_idle_out("rst_async");
    chk("rst_async_addr", pmem_address, 16'h0);
    chk("rst_async_wdata", pmem_wdata, 128'h0);
    @(negedge clk); drv(0, 16'h0000, 0, 0, '0, '0, 0, '0); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drv(0, 16'h0000, 0, 0, '0, '0, (k == 1), A5); #1;
      chk_idle_out($sformatf("rst_after%0d", k));
    end

    // fixed D priority under continuous contention
    @(negedge clk);
    f_i_read = 1; f_i_address = 16'hAAAA; f_d_read = 1; f_d_address = 16'hBBBB; #1;
    chk("fp_idle_read", f_pmem_read, 1'b0);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); f_pmem_resp = 0; #1;
      chk($sformatf("fp%0d_read", g), f_pmem_read, 1'b1);
      chk($sformatf("fp%0d_addr", g), f_pmem_address, 16'hBBBB);
      @(negedge clk); f_pmem_resp = 1; f_pmem_rdata = R2 ^ 128'(g); #1;
      chk($sformatf("fp%0d_d_resp", g), f_d_resp, 1'b1);
      chk($sformatf("fp%0d_i_resp", g), f_i_resp, 1'b0);
      chk($sformatf("fp%0d_d_rdata", g), f_d_rdata, R2 ^ 128'(g));
      chk($sformatf("fp%0d_i_rdata", g), f_i_rdata, R2 ^ 128'(g));
      @(negedge clk); f_pmem_resp = 0; #1;
      chk($sformatf("fp%0d_gap", g), f_pmem_read | f_pmem_write, 1'b0);
    end
    @(negedge clk); f_i_read = 0; f_d_read = 0;

    // randomized traffic against the transaction-level model (DUT idle, last grant I)
    m_busy = 0; m_last = 0; m_side = 0; m_wr = 0; m_addr = '0; m_data = '0;
    i_pend = 0; d_pend = 0; n_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e_i, e_d;
      int op;
      @(negedge clk);
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_address = 16'($urandom);
      end
      i_read = i_pend;
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1;
        op = $urandom_range(0, 4);
        d_read  = (op <= 1) || (op == 4);
        d_write = (op >= 2);
        d_address = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!d_pend) begin d_read = 0; d_write = 0; end
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e_i = m_busy && !m_side && pmem_resp;
      e_d = m_busy && m_side && pmem_resp;
      chk("rnd_i_resp", i_resp, e_i);
      chk("rnd_d_resp", d_resp, e_d);
      chk("rnd_pmem_read", pmem_read, m_busy && !m_wr);
      chk("rnd_pmem_write", pmem_write, m_busy && m_wr);
      if (m_busy) chk("rnd_pmem_address", pmem_address, m_addr);
      if (m_busy && m_wr) chk("rnd_pmem_wdata", pmem_wdata, m_data);
      if (e_i) begin chk("rnd_i_rdata", i_rdata, pmem_rdata); i_pend = 0; n_done++; end
      if (e_d) begin chk("rnd_d_rdata", d_rdata, pmem_rdata); d_pend = 0; n_done++; end
      if (!m_busy) begin
        if (i_read || d_read || d_write) begin
          m_side = (d_read || d_write) && (!i_read || !m_last);
          m_last = m_side;
          m_busy = 1;
          if (m_side) begin m_wr = d_write; m_addr = d_address; m_data = d_wdata; end
          else begin m_wr = 0; m_addr = i_address; end
        end
      end else if (pmem_resp) begin
        m_busy = 0;
      end
    end
    chk("rnd_progress", (n_done > 100), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single physical-memory port between the instruction cache (read-only, I-side) and the data cache (read/write, D-side).
- Sits between the two cache_control/cache_datapath instances and pmem in the mp3 top level.
- Registers each granted request and holds it on pmem until pmem_resp, then routes the response and line data back to the owner.
- When both sides request at the same time, the winner is chosen by round-robin (default) or by fixed D-priority.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, cache line width (lc3b_mem_data).
- ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = D-side always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-cache line-read request; held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_resp  out  1  I-side completion pulse.
- i_rdata  out  LINE_W  line data to I-cache.
- d_read  in  1  D-cache line-read request; held until d_resp.
- d_write  in  1  D-cache line-writeback request; held until d_resp.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache writeback line.
- d_resp  out  1  D-side completion pulse.
- d_rdata  out  LINE_W  line data to D-cache.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_wdata  out  LINE_W  physical memory write line.
- pmem_resp  in  1  physical memory completion.
- pmem_rdata  in  LINE_W  physical memory read line.

Behaviour:
- **States:** IDLE, SERVE_I, SERVE_D, held in a 2-bit state register. Encoding is free; no other states.
- **Reset (async, rst_n=0):**
  - state=IDLE, last_grant=I (so D wins the first tie).
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_resp=0, d_resp=0.
  - Any transaction in flight is abandoned; no resp is issued for it.
- **IDLE:** each cycle samples req_i=i_read and req_d=d_read|d_write.
  - Only req_d: go to SERVE_D.
  - Only req_i: go to SERVE_I.
  - Both, ROUND_ROBIN=1: grant the side opposite last_grant.
  - Both, ROUND_ROBIN=0: grant D.
  - Neither: stay in IDLE.
- **On grant (same edge as the state change):**
  - Latch address, wdata and op into the pmem output registers.
  - Update last_grant to the granted side.
  - pmem_read/pmem_write go high in the first cycle of SERVE_x (one cycle after the request is seen in IDLE).
  - If d_read and d_write are both high (illegal), perform the write.
- **SERVE_x:**
  - pmem outputs are held stable until pmem_resp=1.
  - In the pmem_resp cycle, x_resp=1 combinationally and x_rdata=pmem_rdata. The other side's resp stays 0.
  - Next edge: state goes to IDLE and the pmem strobes clear.
- **Post-response gap:** the mandatory IDLE cycle gives requesters one edge to drop their request, so stale requests are never re-granted.
  - Minimum gap between pmem_resp and the next pmem strobe is 2 cycles (resp at M, IDLE at M+1, strobe at M+2).
- **Requester drops its request mid-SERVE:** the transaction still completes on pmem and resp still pulses. The arbiter never aborts pmem.
- **pmem_resp outside SERVE_x:** ignored; no resp is generated.
- **Data outputs:**
  - i_rdata and d_rdata both pass pmem_rdata through unconditionally; only the resp signals qualify them.
  - pmem_wdata is registered and is don't-care during reads.
- **Latency:** unloaded read = 1 cycle + pmem latency. The non-granted side waits for full completion plus the IDLE gap.

Test Plan:
1. **Single I read:** i_read=1, i_address=0x1230; pmem_resp after 3 cycles with rdata=0xA5..A5.
   - Required: pmem_read high from cycle 1, pmem_address=0x1230.
   - i_resp pulses exactly 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
2. **D writeback:** d_write=1, d_address=0x4000, d_wdata=0x0123..CDEF.
   - Required: pmem_write=1 with that address and data held stable until pmem_resp; d_resp pulses once; pmem_read stays 0.
3. **Round-robin contention from reset:** i_read and d_read held continuously.
   - Required: grant order D, I, D, I.
   - Each grant separated by one IDLE cycle after resp.
   - With ROUND_ROBIN=0, the order is D, D, D.
4. **Illegal D request:** d_read=d_write=1.
   - Required: pmem_write=1, pmem_read=0.
5. **Drop mid-SERVE, then reset mid-SERVE:**
   - Drop: after SERVE_I starts, i_read drops. Required: pmem_read held until pmem_resp, i_resp still pulses.
   - Reset: rst_n=0 asserted during SERVE_D. Required: all outputs 0 immediately (asynchronous); after release, an idle bench shows no resp.
6. **Stray response:** pmem_resp=1 while in IDLE.
   - Required: no i_resp/d_resp, state remains IDLE.
